// File: rtl/mips_pkg.sv
// Shared MIPS control encodings: FSM states, opcode/funct constants and datapath select codes.
// Used by the control FSM, the datapath muxes and the ALU control.
package mips_pkg;

  typedef enum logic [3:0] {
    ST_RESET    = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_EXEC_I   = 4'd4,
    ST_WB_R     = 4'd5,
    ST_WB_I     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_WB_MEM   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_TRAP     = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_FUNCT = 3'b010,
    ALU_LUI   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_SLT   = 3'b110
  } alu_op_t;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_EXC    = 2'b11
  } pc_source_t;

  typedef enum logic [1:0] {
    RD_RT = 2'b00,
    RD_RD = 2'b01,
    RD_RA = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'b00,
    CAUSE_UNDEF = 2'b01,
    CAUSE_OVF   = 2'b10
  } cause_t;

  typedef struct packed {
    logic        pc_write;
    logic        pc_wr_cond;
    logic        branch_ne;
    logic        iord;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    reg_dst_t    reg_dst;
    mem_to_reg_t mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    alu_op_t     alu_op;
    pc_source_t  pc_source;
    logic        epc_write;
  } ctrl_t;

  function automatic logic funct_known(input logic [5:0] fn);
    case (fn)
      FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_SLT: funct_known = 1'b1;
      default:                                                 funct_known = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_ctrl_fsm.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and traps.
// Strobes are registered from the next state, so they change together with the state register.
module mips_ctrl_fsm
  import mips_pkg::*;
#(
  parameter int MEM_WAIT = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       alu_ovf,
  output logic       pc_write,
  output logic       pc_wr_cond,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       epc_write,
  output logic [1:0] cause,
  output logic [3:0] state
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  state_t     state_r, next_state_s;
  logic [3:0] cnt_r, cnt_next_s;
  cause_t     cause_r, cause_next_s;
  ctrl_t      ctrl_r, ctrl_next_s;
  logic       last_s;
  logic       unused_s;

  // Branch resolution happens in the datapath; the zero flag is not needed here.
  assign unused_s = alu_zero;
  assign last_s   = (cnt_r == WAIT_LAST);

  function automatic ctrl_t decode_ctrl(input state_t st, input logic [5:0] op, input logic last);
    ctrl_t c;
    c = '0;
    case (st)
      ST_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = last;
        c.pc_write  = last;
      end
      ST_DECODE:   c.alu_src_b = 2'b11;
      ST_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      ST_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        case (op)
          OP_ANDI: c.alu_op = ALU_AND;
          OP_ORI:  c.alu_op = ALU_OR;
          OP_LUI:  c.alu_op = ALU_LUI;
          default: c.alu_op = ALU_ADD;
        endcase
      end
      ST_WB_R: begin
        c.reg_write = 1'b1;
        c.reg_dst   = RD_RD;
      end
      ST_WB_I:     c.reg_write = 1'b1;
      ST_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      ST_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      ST_WB_MEM: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = M2R_MDR;
      end
      ST_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      ST_BRANCH: begin
        c.alu_src_a  = 1'b1;
        c.alu_op     = ALU_SUB;
        c.pc_wr_cond = 1'b1;
        c.pc_source  = PCS_ALUOUT;
        c.branch_ne  = (op == OP_BNE);
      end
      ST_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
        if (op == OP_JAL) begin
          c.reg_write  = 1'b1;
          c.reg_dst    = RD_RA;
          c.mem_to_reg = M2R_PC;
        end else begin
          c.reg_write  = 1'b0;
        end
      end
      ST_TRAP: begin
        c.epc_write = 1'b1;
        c.pc_write  = 1'b1;
        c.pc_source = PCS_EXC;
      end
      default:     c = '0;
    endcase
    return c;
  endfunction

  // Next-state, trap cause and wait-counter logic.
  always_comb begin
    next_state_s = ST_RESET;
    cause_next_s = cause_r;
    case (state_r)
      ST_RESET: next_state_s = ST_FETCH;
      ST_FETCH: next_state_s = last_s ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_RTYPE:                         next_state_s = ST_EXEC_R;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state_s = ST_EXEC_I;
          OP_LW, OP_SW:                     next_state_s = ST_MEM_ADDR;
          OP_BEQ, OP_BNE:                   next_state_s = ST_BRANCH;
          OP_J, OP_JAL:                     next_state_s = ST_JUMP;
          default: begin
            next_state_s = ST_TRAP;
            cause_next_s = CAUSE_UNDEF;
          end
        endcase
      end
      ST_EXEC_R: begin
        if (!funct_known(funct)) begin
          next_state_s = ST_TRAP;
          cause_next_s = CAUSE_UNDEF;
        end else if (funct == FN_ADD && alu_ovf) begin
          next_state_s = ST_TRAP;
          cause_next_s = CAUSE_OVF;
        end else begin
          next_state_s = ST_WB_R;
        end
      end
      ST_EXEC_I: begin
        if (opcode == OP_ADDI && alu_ovf) begin
          next_state_s = ST_TRAP;
          cause_next_s = CAUSE_OVF;
        end else begin
          next_state_s = ST_WB_I;
        end
      end
      ST_MEM_ADDR: next_state_s = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   next_state_s = last_s ? ST_WB_MEM : ST_MEM_RD;
      ST_MEM_WR:   next_state_s = last_s ? ST_FETCH : ST_MEM_WR;
      ST_WB_R, ST_WB_I, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_TRAP: next_state_s = ST_FETCH;
      default:     next_state_s = ST_RESET;
    endcase

    if (next_state_s == state_r) begin
      cnt_next_s = cnt_r + 4'd1;
    end else begin
      cnt_next_s = 4'd0;
    end

    ctrl_next_s = decode_ctrl(next_state_s, opcode, cnt_next_s == WAIT_LAST);
  end

  // State, counter, cause and registered strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_RESET;
      cnt_r   <= 4'd0;
      cause_r <= CAUSE_NONE;
      ctrl_r  <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      ctrl_r  <= ctrl_next_s;
      if (next_state_s == ST_TRAP && state_r != ST_TRAP) begin
        cause_r <= cause_next_s;
      end else begin
        cause_r <= cause_r;
      end
    end
  end

  assign pc_write   = ctrl_r.pc_write;
  assign pc_wr_cond = ctrl_r.pc_wr_cond;
  assign branch_ne  = ctrl_r.branch_ne;
  assign iord       = ctrl_r.iord;
  assign mem_read   = ctrl_r.mem_read;
  assign mem_write  = ctrl_r.mem_write;
  assign ir_write   = ctrl_r.ir_write;
  assign reg_dst    = ctrl_r.reg_dst;
  assign mem_to_reg = ctrl_r.mem_to_reg;
  assign reg_write  = ctrl_r.reg_write;
  assign alu_src_a  = ctrl_r.alu_src_a;
  assign alu_src_b  = ctrl_r.alu_src_b;
  assign alu_op     = ctrl_r.alu_op;
  assign pc_source  = ctrl_r.pc_source;
  assign epc_write  = ctrl_r.epc_write;
  assign cause      = cause_r;
  assign state      = state_r;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Directed bench for mips_ctrl_fsm (MEM_WAIT=2): walks R-type, lw, bne, jal, traps and reset mid-store.
module tb_mips_ctrl_fsm;
  import mips_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       alu_zero, alu_ovf;
  logic       pc_write, pc_wr_cond, branch_ne, iord, mem_read, mem_write, ir_write;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source, cause;
  logic       reg_write, alu_src_a, epc_write;
  logic [2:0] alu_op;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;
  logic [1:0] cur_cause;

  mips_ctrl_fsm #(.MEM_WAIT(2)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .pc_write(pc_write), .pc_wr_cond(pc_wr_cond), .branch_ne(branch_ne),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .epc_write(epc_write), .cause(cause), .state(state)
  );

  always #5 clock = ~clock;

  // Observed outputs packed in the same order as expv() below.
  wire [26:0] obs = {state, pc_write, pc_wr_cond, branch_ne, iord, mem_read, mem_write,
                     ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                     alu_op, pc_source, epc_write, cause};

  function automatic logic [26:0] expv(
      input logic [3:0] st, input logic pcw, input logic pwc, input logic bne,
      input logic io, input logic mr, input logic mw, input logic irw,
      input logic [1:0] rdst, input logic [1:0] m2r, input logic rw, input logic asa,
      input logic [1:0] asb, input logic [2:0] aop, input logic [1:0] psrc,
      input logic epc, input logic [1:0] cs);
    return {st, pcw, pwc, bne, io, mr, mw, irw, rdst, m2r, rw, asa, asb, aop, psrc, epc, cs};
  endfunction

  task automatic chk(input string tag, input logic [26:0] o, input logic [26:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Three fetch cycles (MEM_WAIT=2) followed by DECODE.
  task automatic fetch_decode(input string tag);
    tick(); chk({tag, "_f0"}, obs, expv(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,cur_cause));
    tick(); chk({tag, "_f1"}, obs, expv(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,cur_cause));
    tick(); chk({tag, "_f2"}, obs, expv(4'd1, 1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1, 2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,cur_cause));
    tick(); chk({tag, "_dec"}, obs, expv(4'd2, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd3,3'd0,2'd0,1'b0,cur_cause));
  endtask

  initial begin
    cur_cause = 2'd0;
    reset = 1'b1; opcode = 6'h00; funct = 6'h20; alu_zero = 1'b0; alu_ovf = 1'b0;
    #2;
    chk("reset_async", obs, 27'd0);
    tick(); tick();
    chk("reset_held", obs, 27'd0);
    reset = 1'b0;

    // add, no overflow
    fetch_decode("add");
    tick(); chk("add_exec", obs, expv(4'd3, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b1,2'd0,3'd2,2'd0,1'b0,cur_cause));
    tick(); chk("add_wb",   obs, expv(4'd5, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd1,2'd0,1'b1,1'b0,2'd0,3'd0,2'd0,1'b0,cur_cause));

    // lw
    opcode = 6'h23;
    fetch_decode("lw");
    tick(); chk("lw_addr", obs, expv(4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b1,2'd2,3'd0,2'd0,1'b0,cur_cause));
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("lw_rd%0d", i), obs, expv(4'd8, 1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,cur_cause));
    end
    tick(); chk("lw_wb", obs, expv(4'd9, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd1,1'b1,1'b0,2'd0,3'd0,2'd0,1'b0,cur_cause));

    // bne, not taken condition handled by datapath
    opcode = 6'h05; alu_zero = 1'b0;
    fetch_decode("bne");
    tick(); chk("bne_br", obs, expv(4'd11, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b1,2'd0,3'd1,2'd1,1'b0,cur_cause));

    // jal
    opcode = 6'h03;
    fetch_decode("jal");
    tick(); chk("jal_jump", obs, expv(4'd12, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd2,2'd2,1'b1,1'b0,2'd0,3'd0,2'd2,1'b0,cur_cause));

    // undefined opcode
    opcode = 6'h3F;
    fetch_decode("undef");
    cur_cause = 2'd1;
    tick(); chk("undef_trap", obs, expv(4'd13, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd3,1'b1,cur_cause));

    // addi overflow: trap, no writeback
    opcode = 6'h08; alu_ovf = 1'b1;
    fetch_decode("addi");
    tick(); chk("addi_exec", obs, expv(4'd4, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b1,2'd2,3'd0,2'd0,1'b0,cur_cause));
    cur_cause = 2'd2;
    tick(); chk("addi_trap", obs, expv(4'd13, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd3,1'b1,cur_cause));
    alu_ovf = 1'b0;

    // sw, reset mid-access
    opcode = 6'h2B;
    fetch_decode("sw");
    tick(); chk("sw_addr", obs, expv(4'd7, 1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b1,2'd2,3'd0,2'd0,1'b0,cur_cause));
    tick(); chk("sw_wr0", obs, expv(4'd10, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd0,3'd0,2'd0,1'b0,cur_cause));
    reset = 1'b1;
    #1;
    cur_cause = 2'd0;
    chk("sw_reset_drop", obs, 27'd0);
    tick();
    reset = 1'b0;
    tick(); chk("post_reset_fetch", obs, expv(4'd1, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'd0,2'd0,1'b0,1'b0,2'd1,3'd0,2'd0,1'b0,cur_cause));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
